hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL expose parameter AW, default 5, register-address width.
REQ-002 The block SHALL expose parameter MEM_WAIT, default 2, extra cycles a load occupies MEM (legal 0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 id_rs1, id_rs2  input  AW each  source registers of instruction in IF/ID.
REQ-006 id_valid  input  1  IF/ID holds a real instruction.
REQ-007 ex_rs1, ex_rs2, ex_rd  input  AW each  ID/EX source and destination registers.
REQ-008 ex_regwrite, ex_memread  input  1 each  ID/EX control bits.
REQ-009 mem_rd, mem_regwrite  input  AW, 1  EX/MEM destination and write enable.
REQ-010 wb_rd, wb_regwrite  input  AW, 1  MEM/WB destination and write enable.
REQ-011 flush  input  1  branch taken; IF/ID and ID/EX are being squashed this cycle.
REQ-012 clr_stats  input  1  synchronous clear of stall_cycles.
REQ-013 forward_a, forward_b  output  2 each  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-014 id_fwd_a, id_fwd_b  output  1 each  WB-to-decode bypass of id_rs1/id_rs2.
REQ-015 stall_if  output  1  hold PC and IF/ID.
REQ-016 bubble_ex  output  1  zero ID/EX control (insert NOP).
REQ-017 freeze  output  1  hold PC, IF/ID, ID/EX, EX/MEM; bubble MEM/WB.
REQ-018 stall_cycles  output  16  saturating stall-cycle counter.

Function
REQ-019 forward_a SHALL be 10 when mem_regwrite & mem_rd!=0 & mem_rd==ex_rs1, else 01 when wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1, else 00.
REQ-020 forward_b SHALL be computed identically and independently using ex_rs2; a match on one operand never blocks the other.
REQ-021 id_fwd_a/id_fwd_b SHALL be 1 when wb_regwrite & wb_rd!=0 & wb_rd equals id_rs1/id_rs2.
REQ-022 Forwarding and bypass outputs SHALL be combinational, zero latency; register 0 never forwards.
REQ-023 load_use SHALL be id_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-024 FSM states SHALL be RUN and MEM_FREEZE, with a 4-bit wait counter.
REQ-025 In RUN, stall_if = bubble_ex = load_use & ~flush; freeze = 0.
REQ-026 RUN -> MEM_FREEZE on an edge where ex_memread=1, state=RUN, MEM_WAIT>0 (flush does not suppress); counter loads MEM_WAIT-1.
REQ-027 In MEM_FREEZE, freeze=1, stall_if=0, bubble_ex=0; counter decrements each cycle; at counter 0 next state is RUN.
REQ-028 freeze SHALL therefore be high for exactly MEM_WAIT consecutive cycles, starting the cycle after the load leaves EX.
REQ-029 With MEM_WAIT=0 the FSM SHALL remain in RUN permanently and freeze SHALL stay 0.
REQ-030 flush SHALL NOT abort MEM_FREEZE (the frozen load is older than the branch).
REQ-031 stall_cycles SHALL increment by 1 each cycle stall_if|freeze is 1, saturate at 0xFFFF, and go to 0 on clr_stats (clr_stats wins over increment).

Reset
REQ-032 rst SHALL asynchronously force state RUN, counter 0, stall_cycles 0.
REQ-033 While rst is high, stall_if, bubble_ex, freeze SHALL be 0 and forward_a/forward_b/id_fwd_* SHALL be 0.
REQ-034 Reset asserted mid-MEM_FREEZE SHALL drop freeze immediately; after release the block starts in RUN.

Verification
REQ-035 ex_rs1=5, mem_rd=5, mem_regwrite=1, wb_rd=5, wb_regwrite=1 -> forward_a=10; drop mem_regwrite -> forward_a=01.
REQ-036 ex_rs1=3, ex_rs2=7, mem_rd=3, wb_rd=7, both regwrite=1 -> forward_a=10 and forward_b=01 same cycle; mem_rd=0 match -> 00.
REQ-037 ex_memread=1, ex_rd=4, id_rs2=4, id_valid=1, MEM_WAIT=0 -> stall_if=bubble_ex=1 one cycle; same with flush=1 -> both 0.
REQ-038 MEM_WAIT=2, load in EX at cycle N -> freeze=1 cycles N+1,N+2, 0 at N+3; stall_cycles incremented by 2.
REQ-039 rst pulsed at cycle N+1 of REQ-038 -> freeze=0 immediately, stall_cycles=0, state RUN after release.
REQ-040 Hold stall_if for 70000 cycles -> stall_cycles saturates at 0xFFFF; clr_stats=1 -> 0 next edge.

Source files
------------

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Pipeline hazard unit for a 5-stage in-order core. Provides
//               EX operand forwarding, WB-to-decode bypass, load-use stall
//               and bubble generation, a multi-cycle MEM freeze for loads,
//               and a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
  parameter int AW       = 5,
  parameter int MEM_WAIT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] id_rs1,
  input  logic [AW-1:0] id_rs2,
  input  logic          id_valid,
  input  logic [AW-1:0] ex_rs1,
  input  logic [AW-1:0] ex_rs2,
  input  logic [AW-1:0] ex_rd,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic [AW-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] wb_rd,
  input  logic          wb_regwrite,
  input  logic          flush,
  input  logic          clr_stats,
  output logic [1:0]    forward_a,
  output logic [1:0]    forward_b,
  output logic          id_fwd_a,
  output logic          id_fwd_b,
  output logic          stall_if,
  output logic          bubble_ex,
  output logic          freeze,
  output logic [15:0]   stall_cycles
);

  typedef enum logic [0:0] {
    RUN        = 1'b0,
    MEM_FREEZE = 1'b1
  } state_t;

  // A load with no extra MEM latency never enters the freeze state.
  localparam bit       HAS_WAIT  = (MEM_WAIT > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(MEM_WAIT - 1) : 4'd0;

  state_t     state;
  state_t     state_next;
  logic [3:0] wait_cnt;
  logic [3:0] wait_cnt_next;
  logic       load_use;
  logic       mem_hit_a;
  logic       mem_hit_b;
  logic       wb_hit_a;
  logic       wb_hit_b;

  // Producer/consumer register matches; register 0 is hardwired and never forwards.
  always_comb begin
    mem_hit_a = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs1);
    mem_hit_b = mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs2);
    wb_hit_a  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs1);
    wb_hit_b  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == ex_rs2);
  end

  // Operand select and decode bypass; the younger EX/MEM result has priority.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    id_fwd_a  = 1'b0;
    id_fwd_b  = 1'b0;
    if (!rst) begin
      if (mem_hit_a)     forward_a = 2'b10;
      else if (wb_hit_a) forward_a = 2'b01;
      if (mem_hit_b)     forward_b = 2'b10;
      else if (wb_hit_b) forward_b = 2'b01;
      id_fwd_a = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs1);
      id_fwd_b = wb_regwrite && (wb_rd != '0) && (wb_rd == id_rs2);
    end
  end

  // A load in EX whose destination feeds the instruction in decode.
  always_comb begin
    load_use = id_valid && ex_memread && (ex_rd != '0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
  end

  // State and wait-counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Next-state and stall/freeze outputs. A branch flush never aborts a freeze
  // because the frozen load is older than the branch.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    stall_if      = 1'b0;
    bubble_ex     = 1'b0;
    freeze        = 1'b0;
    case (state)
      RUN: begin
        stall_if  = load_use && !flush;
        bubble_ex = load_use && !flush;
        if (ex_memread && HAS_WAIT) begin
          state_next    = MEM_FREEZE;
          wait_cnt_next = WAIT_LOAD;
        end
      end
      MEM_FREEZE: begin
        freeze = 1'b1;
        if (wait_cnt == 4'd0) begin
          state_next = RUN;
        end else begin
          wait_cnt_next = wait_cnt - 4'd1;
        end
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = 4'd0;
      end
    endcase
    if (rst) begin
      stall_if  = 1'b0;
      bubble_ex = 1'b0;
      freeze    = 1'b0;
    end
  end

  // Saturating count of cycles the front end is held; clear takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (clr_stats) begin
      stall_cycles <= 16'd0;
    end else if ((stall_if || freeze) && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_unit
// Description : Bench for hazard_forward_unit with MEM_WAIT=0 and MEM_WAIT=2
//               instances sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic          id_valid, ex_regwrite, ex_memread, mem_regwrite, wb_regwrite;
  logic          flush, clr_stats;

  logic [1:0]  fa0, fb0, fa2, fb2;
  logic        ia0, ib0, ia2, ib2;
  logic        st0, bu0, fz0, st2, bu2, fz2;
  logic [15:0] sc0, sc2;

  int checks;
  int errors;

  // Model state: remaining freeze cycles and stall count for each instance.
  int mw  [2];
  int rem [2];
  int cnt [2];

  hazard_forward_unit #(.AW(AW), .MEM_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_valid(id_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .flush(flush), .clr_stats(clr_stats),
    .forward_a(fa0), .forward_b(fb0), .id_fwd_a(ia0), .id_fwd_b(ib0),
    .stall_if(st0), .bubble_ex(bu0), .freeze(fz0), .stall_cycles(sc0)
  );

  hazard_forward_unit #(.AW(AW), .MEM_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_valid(id_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .flush(flush), .clr_stats(clr_stats),
    .forward_a(fa2), .forward_b(fb2), .id_fwd_a(ia2), .id_fwd_b(ib2),
    .stall_if(st2), .bubble_ex(bu2), .freeze(fz2), .stall_cycles(sc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_fwd(input logic [AW-1:0] rs);
    if (rst) return 0;
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return 2;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return 1;
    return 0;
  endfunction

  function automatic int exp_byp(input logic [AW-1:0] rs);
    return (!rst && wb_regwrite && wb_rd != 0 && wb_rd == rs) ? 1 : 0;
  endfunction

  function automatic bit model_lu();
    return id_valid && ex_memread && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  endfunction

  function automatic int exp_stall(input int k);
    return (!rst && rem[k] == 0 && model_lu() && !flush) ? 1 : 0;
  endfunction

  function automatic int exp_freeze(input int k);
    return (!rst && rem[k] > 0) ? 1 : 0;
  endfunction

  // Reference model: a load starts MEM_WAIT freeze cycles unless already frozen.
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        rem[k] = 0;
        cnt[k] = 0;
      end else begin
        bit busy;
        busy = (rem[k] == 0 && model_lu() && !flush) || (rem[k] > 0);
        if (clr_stats) cnt[k] = 0;
        else if (busy && cnt[k] < 65535) cnt[k] = cnt[k] + 1;
        if (rem[k] > 0) rem[k] = rem[k] - 1;
        else if (ex_memread && mw[k] > 0) rem[k] = mw[k];
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    check("m0_fwd_a", fa0, exp_fwd(ex_rs1));
    check("m0_fwd_b", fb0, exp_fwd(ex_rs2));
    check("m0_idf_a", ia0, exp_byp(id_rs1));
    check("m0_idf_b", ib0, exp_byp(id_rs2));
    check("m0_stall", st0, exp_stall(0));
    check("m0_bubble", bu0, exp_stall(0));
    check("m0_freeze", fz0, exp_freeze(0));
    check("m0_cnt", sc0, cnt[0]);
    check("m2_fwd_a", fa2, exp_fwd(ex_rs1));
    check("m2_fwd_b", fb2, exp_fwd(ex_rs2));
    check("m2_idf_a", ia2, exp_byp(id_rs1));
    check("m2_idf_b", ib2, exp_byp(id_rs2));
    check("m2_stall", st2, exp_stall(1));
    check("m2_bubble", bu2, exp_stall(1));
    check("m2_freeze", fz2, exp_freeze(1));
    check("m2_cnt", sc2, cnt[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
    mem_rd = '0; wb_rd = '0; id_valid = 1'b0; ex_regwrite = 1'b0;
    ex_memread = 1'b0; mem_regwrite = 1'b0; wb_regwrite = 1'b0;
    flush = 1'b0; clr_stats = 1'b0;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    checks = 0;
    errors = 0;
    mw[0] = 0;
    mw[1] = 2;
    clear_in();
    rst = 1'b1;
    ex_rs1 = 5; mem_rd = 5; mem_regwrite = 1; wb_rd = 5; wb_regwrite = 1; id_rs1 = 5;
    #3;
    check("rst_fwd_a", fa0, 0);
    check("rst_idfwd", ia2, 0);
    check("rst_cnt", sc2, 0);

    // EX/MEM beats MEM/WB; dropping EX/MEM write falls back to MEM/WB.
    @(posedge clk); #1 rst = 1'b0;
    #1 check("fwd_a_mem", fa0, 2);
    mem_regwrite = 0;
    #1 check("fwd_a_wb", fa0, 1);

    // Independent operands, decode bypass, register 0 never forwards.
    tick(); clear_in();
    ex_rs1 = 3; ex_rs2 = 7; mem_rd = 3; wb_rd = 7; mem_regwrite = 1; wb_regwrite = 1;
    id_rs1 = 7; id_rs2 = 3;
    #1;
    check("fwd_a_indep", fa2, 2);
    check("fwd_b_indep", fb2, 1);
    check("idfwd_a", ia0, 1);
    check("idfwd_b", ib0, 0);
    ex_rs1 = 0; mem_rd = 0;
    #1 check("fwd_a_r0", fa2, 0);

    // Load-use stall; flush suppresses it.
    tick(); clear_in();
    ex_memread = 1; ex_rd = 4; id_rs2 = 4; id_valid = 1;
    #1;
    check("lu_stall", st0, 1);
    check("lu_bubble", bu0, 1);
    check("lu_stall_m2", st2, 1);
    flush = 1;
    #1;
    check("lu_flush_stall", st0, 0);
    check("lu_flush_bubble", bu0, 0);

    // Freeze ignores flush and lasts two cycles on the MEM_WAIT=2 instance.
    tick(); clear_in(); flush = 1;
    #1;
    check("lu_one_cycle", st0, 0);
    check("frz_flush_1", fz2, 1);
    check("frz_none_m0", fz0, 0);
    tick();
    #1 check("frz_flush_2", fz2, 1);
    tick(); flush = 0;
    #1 check("frz_end", fz2, 0);

    // Freeze timing and stall count for a lone load.
    clr_stats = 1;
    tick(); clr_stats = 0; ex_memread = 1; ex_rd = 4;
    #1;
    check("frz_n", fz2, 0);
    check("cnt_n", sc2, 0);
    tick(); clear_in();
    #1;
    check("frz_n1", fz2, 1);
    check("cnt_n1", sc2, 0);
    tick();
    #1;
    check("frz_n2", fz2, 1);
    check("cnt_n2", sc2, 1);
    tick();
    #1;
    check("frz_n3", fz2, 0);
    check("cnt_n3", sc2, 2);

    // Reset in the middle of a freeze.
    tick(); ex_memread = 1; ex_rd = 4;
    tick(); clear_in();
    #1 check("frz_pre_rst", fz2, 1);
    rst = 1;
    #1;
    check("frz_rst", fz2, 0);
    check("cnt_rst", sc2, 0);
    tick(); rst = 0;
    #1 check("frz_after_rst", fz2, 0);
    tick();
    #1 check("frz_after_rst2", fz2, 0);

    // Counter saturation and clear priority.
    clear_in();
    id_valid = 1; ex_memread = 1; ex_rd = 4; id_rs1 = 4;
    repeat (70000) tick();
    check("sat_m0", sc0, 16'hFFFF);
    check("sat_m2", sc2, 16'hFFFF);
    clr_stats = 1;
    tick(); clr_stats = 0;
    check("clr_m0", sc0, 0);
    check("clr_m2", sc2, 0);
    tick();
    check("post_clr_m0", sc0, 1);
    check("post_clr_m2", sc2, 1);

    clear_in();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
